// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types, defaults and width helper for pwm_tick_gen
package pwm_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PERIOD = 255;

    typedef enum logic [0:0] {
        PWM_IDLE = 1'b0,
        PWM_RUN  = 1'b1
    } pwm_state_e;

    // Duty needs one extra bit so that PERIOD+1 (always-high) is representable.
    function automatic int duty_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/pwm_tick_gen_if.sv
// rtl/pwm_tick_gen_if.sv - duty update valid/ready handshake bundle
// Signals: duty_in (requested high-time in ticks), duty_valid, duty_ready.
// master drives duty_in/duty_valid, slave (the PWM block) drives duty_ready.
interface pwm_tick_gen_if
    import pwm_pkg::*;
#(
    parameter int DUTY_W = duty_w(DEF_WIDTH)
);
    logic [DUTY_W-1:0] duty_in;
    logic              duty_valid;
    logic              duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_duty_shadow.sv
// rtl/pwm_duty_shadow.sv - shadow/pending duty registers and handshake
// Ports: clk, rst_n (async active-low), duty_if (slave handshake),
//        load_pt (period wrap or idle), act_load/act_value (update for duty_act).
// Only instantiated when PWM_SHADOW_EN is defined.
module pwm_duty_shadow
    import pwm_pkg::*;
#(
    parameter int DW = duty_w(DEF_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_tick_gen_if.slave    duty_if,
    input  logic             load_pt,
    output logic             act_load,
    output logic [DW-1:0]    act_value
);

    logic [DW-1:0] shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          transfer;

    assign duty_if.duty_ready = ~pending_q;
    assign transfer           = duty_if.duty_valid & ~pending_q;

    always_comb begin
        shadow_d  = transfer ? duty_if.duty_in : shadow_q;
        pending_d = pending_q;
        act_load  = 1'b0;
        act_value = shadow_q;
        if (load_pt) begin
            // A transfer landing on a load point bypasses the shadow so the
            // new duty governs the period that starts right here.
            act_load  = 1'b1;
            act_value = transfer ? duty_if.duty_in : shadow_q;
            pending_d = 1'b0;
        end else if (transfer) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - tick-driven PWM generator with period-end strobe
// Ports: clock_in, reset_n (async active-low), tick_in (divider enable pulse),
//        en (run enable), duty_if (duty valid/ready handshake, slave),
//        pwm_out (registered PWM), period_end (one-cycle wrap strobe).
// Macro PWM_SHADOW_EN: duty updates are shadowed and applied at period wrap.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic          clock_in,
    input  logic          reset_n,
    input  logic          tick_in,
    input  logic          en,
    pwm_tick_gen_if.slave duty_if,
    output logic          pwm_out,
    output logic          period_end
);

    localparam int               DW   = duty_w(WIDTH);
    localparam logic [0:0]       IDLE = PWM_IDLE;
    localparam logic [0:0]       RUN  = PWM_RUN;
    localparam logic [WIDTH-1:0] TERM = WIDTH'(PERIOD);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    duty_act_q, duty_act_d;
    logic             pwm_out_q, pwm_out_d;
    logic             period_end_q, period_end_d;

    logic             running;
    logic             wrap;
    logic             act_load;
    logic [DW-1:0]    act_value;

    // en is qualified here too so that dropping en clears cnt and pwm_out
    // on the same edge that the FSM returns to IDLE.
    assign running = (state_q == RUN) && en;
    assign wrap    = running && tick_in && (cnt_q == TERM);

`ifdef PWM_SHADOW_EN
    logic load_pt;
    assign load_pt = wrap || (state_q == IDLE);

    pwm_duty_shadow #(.DW(DW)) u_duty_shadow (
        .clk       (clock_in),
        .rst_n     (reset_n),
        .duty_if   (duty_if),
        .load_pt   (load_pt),
        .act_load  (act_load),
        .act_value (act_value)
    );
`else
    assign duty_if.duty_ready = 1'b1;
    assign act_load           = duty_if.duty_valid;
    assign act_value          = duty_if.duty_in;
`endif

    always_comb begin
        state_d = en ? RUN : IDLE;

        cnt_d = cnt_q;
        if (!running) begin
            cnt_d = '0;
        end else if (tick_in) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + WIDTH'(1);
        end

        period_end_d = wrap;
        pwm_out_d    = running && ({1'b0, cnt_q} < duty_act_q);
        duty_act_d   = act_load ? act_value : duty_act_q;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            duty_act_q   <= '0;
            pwm_out_q    <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            duty_act_q   <= duty_act_d;
            pwm_out_q    <= pwm_out_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_out    = pwm_out_q;
    assign period_end = period_end_q;

endmodule
